// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), bout = borrow out.
// One bit per clock, LSB first; a result takes WIDTH cycles after acceptance.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             armed;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor slice on the current LSBs of the operand copies.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      armed <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done  <= 1'b0;
      // armed stays low for the first edge after reset so a start that
      // coincides with reset release is never taken.
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start && armed) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            bout  <= br_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// multi-cycle corner sequences and randomized operations against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check busy/done timing plus the result.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    wait_edge();
    start = 1'b0;
    // Operands must not be used after acceptance.
    a = W'($urandom);
    b = W'($urandom);
    check({name, "_busy_accept"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= W; k++) begin
      wait_edge();
      if (k < W) begin
        check({name, "_run_busy_done"}, {30'd0, busy, done}, 32'b10);
      end else begin
        check({name, "_done_edge"}, {30'd0, busy, done}, 32'b01);
        check({name, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
      end
    end
    wait_edge();
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  // Behavioural reference: plain integer subtraction.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] ed, output logic eb);
    int r;
    r  = int'(av) - int'(bv);
    eb = (r < 0);
    if (r < 0) r = r + (1 << W);
    ed = W'(r);
  endtask

  initial begin
    vec_t         vecs[5];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] ed;
    logic         eb;
    int           dones;
    int           at_k;

    vecs[0] = '{"basic",   8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{"under35", 8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{"under01", 8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{"ffff",    8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{"807f",    8'h80, 8'h7F, 8'h01, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("reset_outputs", {21'd0, busy, done, diff, bout}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge();

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout);

    // Start during RUN is ignored: single done with the first operands' result.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    wait_edge();
    start = 1'b0;
    repeat (3) wait_edge();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    wait_edge();
    start = 1'b0;
    dones = 0;
    at_k  = -1;
    for (int k = 5; k <= 16; k++) begin
      wait_edge();
      if (done) begin
        dones++;
        at_k = k;
      end
    end
    check("midrun_done_count", dones, 1);
    check("midrun_done_at", at_k, 8);
    check("midrun_diff", {24'd0, diff}, 32'h0F);
    check("midrun_bout", {31'd0, bout}, 32'd0);
    check("midrun_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h20; b = 8'h30; start = 1'b1;
    wait_edge();
    for (int k = 1; k <= 8; k++) wait_edge();
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_diff1", {24'd0, diff}, 32'hF0);
    check("b2b_bout1", {31'd0, bout}, 32'd1);
    a = 8'h30; b = 8'h20;
    for (int k = 9; k <= 17; k++) begin
      wait_edge();
      if (k == 9) check("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
      if (k < 17) check("b2b_hold", {23'd0, done, diff}, 32'h0F0);
    end
    start = 1'b0;
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_diff2", {24'd0, diff}, 32'h10);
    check("b2b_bout2", {31'd0, bout}, 32'd0);
    wait_edge();

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'h55; b = 8'h12; start = 1'b1;
    wait_edge();
    start = 1'b0;
    repeat (5) wait_edge();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {21'd0, busy, done, diff, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      wait_edge();
      if (done || busy) dones++;
    end
    check("post_reset_idle", dones, 0);
    check("post_reset_diff", {23'd0, bout, diff}, 32'd0);
    run_op("after_reset", 8'h09, 8'h04, 8'h05, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, ed, eb);
      run_op("rand", ra, rb, ed, eb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
